wb_timer_bank: RTL
==================

Name: wb_timer_bank

Overview:
Wishbone-slave bank of NUM_CH independent timer/PWM channels for the user project area. Successor to the single fixed counter: parametrised channel count, counter width and base address, with a shared prescaler, one-shot/free-run modes, PWM compare and a maskable interrupt. It sits behind the management SoC Wishbone port, and its pwm_o bits drive user IO pads.

Parameters:
NUM_CH, 4, number of timer channels (1..16)
WIDTH, 16, counter/period/compare width in bits (1..32)
BASE_ADDR, 32'h3000_0000, block base address; matched on wbs_adr_i[31:ADDR_W]
ADDR_W, 12, decoded byte-address bits

Ports:
wb_clk_i  in  1  clock; everything is in this domain
wb_rst_ni  in  1  asynchronous active-low reset
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte lane enables
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
pwm_o  out  NUM_CH  per-channel PWM/timer output
irq_o  out  1  OR of (STATUS & IRQ_EN)

Behaviour:
- Reset: wb_rst_ni low asynchronously clears all registers, counters and the prescaler. wbs_ack_o=0, wbs_dat_o=0, pwm_o=0, irq_o=0. Reset mid-transaction drops ack immediately; the pending write is lost.
- Address hit: cyc & stb & (wbs_adr_i[31:ADDR_W]==BASE_ADDR[31:ADDR_W]). Non-hits are never acked.
- Handshake: on a hit with ack low, ack is registered high the next cycle for exactly 1 cycle, then low for at least 1 cycle. This gives 1 wait state, so back-to-back accesses take 2 cycles each.
- Writes commit on the edge that raises ack. wbs_sel_i byte lanes are honoured. Bits above WIDTH are ignored.
- Reads: wbs_dat_o is valid while ack is high. Unused bits read 0.
- Unmapped offsets inside the window are acked, read 0, and writes are ignored.
- Register map (offset): channel n at n*0x10.
  - +0x0 CTRL: bit0 EN, bit1 ONESHOT, bit2 INV.
  - +0x4 PERIOD.
  - +0x8 COMPARE.
  - +0xC COUNT (R/W; a write loads the counter).
- Global registers:
  - 0x100 STATUS, NUM_CH bits, W1C.
  - 0x104 PRESCALE, 16 bits.
  - 0x108 IRQ_EN, NUM_CH bits.
- Prescaler: 16-bit counter; tick=1 when it equals PRESCALE, then it wraps to 0. PRESCALE=0 gives a tick every cycle.
- Channel on a tick with EN=1:
  - If COUNT==PERIOD: COUNT<=0, STATUS[n]<=1, and if ONESHOT then EN<=0.
  - Otherwise COUNT<=COUNT+1.
  - Arithmetic is unsigned, modulo 2^WIDTH.
- Channel with EN=0: COUNT holds.
- pwm_o[n] is registered:
  - EN=1: ((COUNT<COMPARE) ^ INV).
  - EN=0: INV.
- Boundaries:
  - PERIOD=0: COUNT stays 0 and the wrap event fires every tick.
  - COMPARE=0: 0% duty. COMPARE>PERIOD: 100% duty.
  - PERIOD written below the current COUNT: the counter runs up to 2^WIDTH-1, wraps to 0 with no STATUS set, then resumes normally.
- Simultaneous events:
  - Hardware STATUS set in the same cycle as a W1C: the set wins.
  - A COUNT write in the same cycle as a tick: the write wins.
  - A CTRL write in the same cycle as a one-shot auto-clear: the write wins.
- irq_o is registered, so it is 1 cycle after the STATUS/IRQ_EN change.

Decomposition:
- Shared package wb_timer_pkg holds:
  - Register offsets: CH_STRIDE=0x10, OFF_CTRL, OFF_PERIOD, OFF_CMP, OFF_COUNT, OFF_STATUS, OFF_PRESCALE, OFF_IRQEN.
  - CTRL bit indices: CTRL_EN, CTRL_ONESHOT, CTRL_INV.
- One sub-module, wb_timer_channel, instantiated NUM_CH times via generate. It holds CTRL/PERIOD/COMPARE/COUNT, the wrap-event pulse and pwm.
- The top level holds the Wishbone decode/ack, prescaler, STATUS, IRQ_EN and the read mux.

Test Plan:
1. Reset, then read 0x000..0x10C → every read returns 0, each ack is a 1-cycle pulse 1 cycle after stb, and pwm_o=0, irq_o=0.
2. Ch0 setup (PRESCALE=0, PERIOD=9, COMPARE=3, CTRL=1) → pwm_o[0] high 3 of every 10 cycles, STATUS[0] set every 10 cycles. Write 0x1 to STATUS → STATUS clears.
3. Ch1 one-shot (PRESCALE=3, PERIOD=4, CTRL=3) → exactly one wrap after 20 cycles, then CTRL.EN reads 0 and COUNT holds at 0. With IRQ_EN=2, irq_o rises 1 cycle after STATUS[1] is set.
4. Duty extremes (COMPARE=0, then COMPARE=PERIOD+1, INV=1, then EN=0) → 0% duty, then 100% duty, then inverted duty, then pwm_o=INV constant.
5. Collisions: W1C on STATUS in the wrap cycle → STATUS stays 1. COUNT write of 5 in a tick cycle → COUNT reads 5. Byte write with sel=4'b0001 to PERIOD=0xABCD → PERIOD=0xAB<new byte>.
6. Address 0x4000_0000 → no ack. Offset 0x200 → acked, reads 0. Assert wb_rst_ni low while ack is pending → ack drops asynchronously and the write is not committed.

Source files
------------

// File: rtl/wb_timer_pkg.sv
// ============================================================================
// Module : wb_timer_pkg
// Desc   : Register offsets, CTRL bit indices and byte-lane helpers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package wb_timer_pkg;

    localparam int unsigned CH_STRIDE    = 'h10;
    localparam int unsigned OFF_CTRL     = 'h0;
    localparam int unsigned OFF_PERIOD   = 'h4;
    localparam int unsigned OFF_CMP      = 'h8;
    localparam int unsigned OFF_COUNT    = 'hC;
    localparam int unsigned OFF_STATUS   = 'h100;
    localparam int unsigned OFF_PRESCALE = 'h104;
    localparam int unsigned OFF_IRQEN    = 'h108;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_INV     = 2;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    // Replace only the enabled byte lanes of old_v with new_v.
    function automatic logic [31:0] sel_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
        return (old_v & ~lane_mask(sel)) | (new_v & lane_mask(sel));
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_timer_channel.sv
// ============================================================================
// Module : wb_timer_channel
// Desc   : One timer/PWM channel: CTRL, PERIOD, COMPARE, COUNT and pwm output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wb_timer_channel
    import wb_timer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_tick,
    input  logic             i_wr_ctrl,
    input  logic             i_wr_period,
    input  logic             i_wr_cmp,
    input  logic             i_wr_count,
    input  logic [31:0]      i_wdata,
    input  logic [3:0]       i_sel,
    output logic [2:0]       o_ctrl,
    output logic [WIDTH-1:0] o_period,
    output logic [WIDTH-1:0] o_cmp,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap,
    output logic             o_pwm
);

    logic [2:0]       r_ctrl;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_cmp;
    logic [WIDTH-1:0] r_count;
    logic             r_pwm;
    logic             w_en;
    logic             w_step;

    assign w_en   = r_ctrl[CTRL_EN];
    assign w_step = i_tick & w_en;
    // A counter above PERIOD simply rolls over modulo 2^WIDTH without a wrap event.
    assign o_wrap = w_step & (r_count == r_period);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ctrl   <= '0;
            r_period <= '0;
            r_cmp    <= '0;
            r_count  <= '0;
            r_pwm    <= 1'b0;
        end else begin
            if (i_wr_ctrl)
                r_ctrl <= 3'(sel_merge(32'(r_ctrl), i_wdata, i_sel));
            else if (o_wrap && r_ctrl[CTRL_ONESHOT])
                r_ctrl[CTRL_EN] <= 1'b0;

            if (i_wr_period)
                r_period <= WIDTH'(sel_merge(32'(r_period), i_wdata, i_sel));
            if (i_wr_cmp)
                r_cmp <= WIDTH'(sel_merge(32'(r_cmp), i_wdata, i_sel));

            if (i_wr_count)
                r_count <= WIDTH'(sel_merge(32'(r_count), i_wdata, i_sel));
            else if (o_wrap)
                r_count <= '0;
            else if (w_step)
                r_count <= r_count + WIDTH'(1);

            r_pwm <= w_en ? ((r_count < r_cmp) ^ r_ctrl[CTRL_INV]) : r_ctrl[CTRL_INV];
        end
    end

    assign o_ctrl   = r_ctrl;
    assign o_period = r_period;
    assign o_cmp    = r_cmp;
    assign o_count  = r_count;
    assign o_pwm    = r_pwm;

endmodule

`default_nettype wire

// File: rtl/wb_timer_bank.sv
// ============================================================================
// Module : wb_timer_bank
// Desc   : Wishbone slave bank of NUM_CH timer/PWM channels, shared prescaler, IRQ.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wb_timer_bank
    import wb_timer_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          WIDTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          ADDR_W    = 12
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic [NUM_CH-1:0] pwm_o,
    output logic              irq_o
);

    localparam int CH_SHIFT = $clog2(CH_STRIDE);
    localparam int IDX_W    = ADDR_W - CH_SHIFT;

    logic              r_ack;
    logic [31:0]       r_dat;
    logic [15:0]       r_psc;
    logic [15:0]       r_prescale;
    logic [NUM_CH-1:0] r_status;
    logic [NUM_CH-1:0] r_irq_en;
    logic              r_irq;

    logic              w_hit;
    logic              w_acc;
    logic              w_wr;
    logic              w_tick;
    logic              w_in_ch;
    logic [ADDR_W-1:0] w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [CH_SHIFT-1:0] w_fld;
    logic [NUM_CH-1:0] w_w1c;
    logic [NUM_CH-1:0] w_wrap;
    logic [NUM_CH-1:0] w_pwm;
    logic [31:0]       w_rdata;
    logic              w_unused_ok;

    logic [2:0]        w_ctrl   [NUM_CH];
    logic [WIDTH-1:0]  w_period [NUM_CH];
    logic [WIDTH-1:0]  w_cmp    [NUM_CH];
    logic [WIDTH-1:0]  w_count  [NUM_CH];

    assign w_hit   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:ADDR_W] == BASE_ADDR[31:ADDR_W]);
    // One access per ack pulse: a request is only accepted while ack is low.
    assign w_acc   = w_hit & ~r_ack;
    assign w_wr    = w_acc & wbs_we_i;
    assign w_off   = {wbs_adr_i[ADDR_W-1:2], 2'b00};
    assign w_idx   = w_off[ADDR_W-1:CH_SHIFT];
    assign w_fld   = w_off[CH_SHIFT-1:0];
    assign w_in_ch = (w_idx < IDX_W'(NUM_CH));
    assign w_tick  = (r_psc == r_prescale);
    assign w_w1c   = (w_wr && w_off == ADDR_W'(OFF_STATUS))
                   ? NUM_CH'(wbs_dat_i & lane_mask(wbs_sel_i)) : '0;
    assign w_unused_ok = &{1'b0, wbs_adr_i[1:0]};

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic w_sel_ch;
            assign w_sel_ch = w_wr & w_in_ch & (w_idx == IDX_W'(i));

            wb_timer_channel #(
                .WIDTH (WIDTH)
            ) u_ch (
                .i_clk       (wb_clk_i),
                .i_rst_n     (wb_rst_ni),
                .i_tick      (w_tick),
                .i_wr_ctrl   (w_sel_ch & (w_fld == CH_SHIFT'(OFF_CTRL))),
                .i_wr_period (w_sel_ch & (w_fld == CH_SHIFT'(OFF_PERIOD))),
                .i_wr_cmp    (w_sel_ch & (w_fld == CH_SHIFT'(OFF_CMP))),
                .i_wr_count  (w_sel_ch & (w_fld == CH_SHIFT'(OFF_COUNT))),
                .i_wdata     (wbs_dat_i),
                .i_sel       (wbs_sel_i),
                .o_ctrl      (w_ctrl[i]),
                .o_period    (w_period[i]),
                .o_cmp       (w_cmp[i]),
                .o_count     (w_count[i]),
                .o_wrap      (w_wrap[i]),
                .o_pwm       (w_pwm[i])
            );
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        if (w_in_ch) begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (w_idx == IDX_W'(n)) begin
                    case (w_fld)
                        CH_SHIFT'(OFF_CTRL):   w_rdata = 32'(w_ctrl[n]);
                        CH_SHIFT'(OFF_PERIOD): w_rdata = 32'(w_period[n]);
                        CH_SHIFT'(OFF_CMP):    w_rdata = 32'(w_cmp[n]);
                        CH_SHIFT'(OFF_COUNT):  w_rdata = 32'(w_count[n]);
                        default:               w_rdata = '0;
                    endcase
                end
            end
        end else if (w_off == ADDR_W'(OFF_STATUS)) begin
            w_rdata = 32'(r_status);
        end else if (w_off == ADDR_W'(OFF_PRESCALE)) begin
            w_rdata = 32'(r_prescale);
        end else if (w_off == ADDR_W'(OFF_IRQEN)) begin
            w_rdata = 32'(r_irq_en);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_psc      <= '0;
            r_prescale <= '0;
            r_status   <= '0;
            r_irq_en   <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_ack <= w_acc;
            r_dat <= (w_acc && !wbs_we_i) ? w_rdata : '0;
            r_psc <= w_tick ? '0 : r_psc + 16'd1;
            if (w_wr && w_off == ADDR_W'(OFF_PRESCALE))
                r_prescale <= 16'(sel_merge(32'(r_prescale), wbs_dat_i, wbs_sel_i));
            if (w_wr && w_off == ADDR_W'(OFF_IRQEN))
                r_irq_en <= NUM_CH'(sel_merge(32'(r_irq_en), wbs_dat_i, wbs_sel_i));
            // Hardware set is OR-ed in after the clear so a same-cycle wrap is never lost.
            r_status <= (r_status & ~w_w1c) | w_wrap;
            r_irq    <= |(r_status & r_irq_en);
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign pwm_o     = w_pwm;
    assign irq_o     = r_irq;

endmodule

`default_nettype wire
